// File: rtl/ldpc_pkg.sv
// Shared constants and helpers for the min-sum LDPC datapath blocks
// (check-node sequencer, variable-node and check-to-variable stages).
package ldpc_pkg;

    localparam int PREC_DEF = 5;
    localparam int LANE_W   = PREC_DEF + 1;
    localparam logic [PREC_DEF-1:0] MAG_INIT = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } seq_state_t;

    function automatic int lane_width(input int prec);
        return prec + 1;
    endfunction

    // Never returns zero so single-entry indices still get a real bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/min_pair_tree.sv
// Combinational min / second-min / argmin over N magnitude lanes, built as a
// recursive split into lower and upper halves; the lower lane wins ties.
module min_pair_tree
    import ldpc_pkg::*;
#(
    parameter int N    = 3,
    parameter int PREC = PREC_DEF,
    parameter int IW   = idx_width(N)
) (
    input  logic [N*PREC-1:0] mag_i,
    output logic [PREC-1:0]   min_o,
    output logic [PREC-1:0]   sec_o,
    output logic [IW-1:0]     idx_o
);

    generate
        if (N == 1) begin : g_leaf
            assign min_o = mag_i;
            assign sec_o = '1;
            assign idx_o = '0;
        end else begin : g_node
            localparam int NL = N / 2;
            localparam int NH = N - NL;

            logic [PREC-1:0] lo_min, lo_sec, hi_min, hi_sec, loser;
            logic [IW-1:0]   lo_idx, hi_idx;
            logic            hi_wins;

            min_pair_tree #(.N(NL), .PREC(PREC), .IW(IW)) u_lo (
                .mag_i (mag_i[NL*PREC-1:0]),
                .min_o (lo_min),
                .sec_o (lo_sec),
                .idx_o (lo_idx)
            );

            min_pair_tree #(.N(NH), .PREC(PREC), .IW(IW)) u_hi (
                .mag_i (mag_i[N*PREC-1:NL*PREC]),
                .min_o (hi_min),
                .sec_o (hi_sec),
                .idx_o (hi_idx)
            );

            // Strict compare keeps the lower half on equal magnitudes.
            always_comb begin
                hi_wins = hi_min < lo_min;
                min_o   = hi_wins ? hi_min : lo_min;
                idx_o   = hi_wins ? (IW'(NL) + hi_idx) : lo_idx;
                loser   = hi_wins ? lo_min : hi_min;
                sec_o   = loser;
                if (lo_sec < sec_o) sec_o = lo_sec;
                if (hi_sec < sec_o) sec_o = hi_sec;
            end
        end
    endgenerate

endmodule

// File: rtl/check_node_min_sequencer.sv
// Serial check-node reducer: merges beats of GROUP messages into row min,
// second min, argmin and sign parity, then holds the result for downstream.
//   state | meaning
//   ACCUM | collecting beats of the current row
//   HOLD  | row result presented on out_*, waiting for out_ready
module check_node_min_sequencer
    import ldpc_pkg::*;
#(
    parameter int PREC  = PREC_DEF,
    parameter int DEG   = 6,
    parameter int GROUP = 3,
    parameter int IDXW  = idx_width(DEG)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [GROUP*lane_width(PREC)-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [PREC-1:0]                 out_min,
    output logic [PREC-1:0]                 out_sec_min,
    output logic [IDXW-1:0]                 out_min_idx,
    output logic                            out_sign_par,
    output logic [DEG-1:0]                  out_signs
);

    localparam int LW    = lane_width(PREC);
    localparam int BEATS = DEG / GROUP;
    localparam int GIW   = idx_width(GROUP);
    localparam int BW    = idx_width(BEATS);

    seq_state_t        state_q;
    logic [BW-1:0]     beat_q;
    logic [PREC-1:0]   run_min_q, run_sec_q;
    logic [IDXW-1:0]   run_idx_q;
    logic              run_par_q;
    logic [DEG-1:0]    run_signs_q;
    logic              out_valid_q, out_par_q;
    logic [PREC-1:0]   out_min_q, out_sec_q;
    logic [IDXW-1:0]   out_idx_q;
    logic [DEG-1:0]    out_signs_q;

    logic [GROUP*PREC-1:0] lane_mag;
    logic [GROUP-1:0]      lane_sign;
    logic [PREC-1:0]       g_min, g_sec, loser;
    logic [GIW-1:0]        g_idx;
    logic [IDXW-1:0]       g_base;
    logic                  accept, last_beat;
    logic [PREC-1:0]       merge_min_d, merge_sec_d;
    logic [IDXW-1:0]       merge_idx_d;
    logic                  merge_par_d;
    logic [DEG-1:0]        merge_signs_d;

    always_comb begin
        lane_mag  = '0;
        lane_sign = '0;
        for (int k = 0; k < GROUP; k++) begin
            lane_mag[k*PREC +: PREC] = in_data[k*LW +: PREC];
            lane_sign[k]             = in_data[k*LW + PREC];
        end
    end

    min_pair_tree #(.N(GROUP), .PREC(PREC), .IW(GIW)) u_tree (
        .mag_i (lane_mag),
        .min_o (g_min),
        .sec_o (g_sec),
        .idx_o (g_idx)
    );

    assign in_ready  = (state_q == ACCUM) || out_ready;
    assign accept    = in_valid && in_ready;
    assign last_beat = (beat_q == BW'(BEATS - 1));

    // Running registers are already cleared whenever a row starts, so a beat
    // accepted in HOLD merges from the same registers as any other beat.
    always_comb begin
        g_base        = IDXW'(beat_q) * IDXW'(GROUP);
        merge_min_d   = run_min_q;
        merge_idx_d   = run_idx_q;
        loser         = g_min;
        if (g_min < run_min_q) begin
            merge_min_d = g_min;
            merge_idx_d = g_base + IDXW'(g_idx);
            loser       = run_min_q;
        end
        merge_sec_d   = loser;
        if (run_sec_q < merge_sec_d) merge_sec_d = run_sec_q;
        if (g_sec < merge_sec_d)     merge_sec_d = g_sec;
        merge_par_d   = run_par_q ^ (^lane_sign);
        merge_signs_d = run_signs_q | (DEG'(lane_sign) << g_base);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            beat_q      <= '0;
            run_min_q   <= '1;
            run_sec_q   <= '1;
            run_idx_q   <= '0;
            run_par_q   <= 1'b0;
            run_signs_q <= '0;
            out_valid_q <= 1'b0;
            out_min_q   <= '0;
            out_sec_q   <= '0;
            out_idx_q   <= '0;
            out_par_q   <= 1'b0;
            out_signs_q <= '0;
        end else if (accept && last_beat) begin
            out_min_q   <= merge_min_d;
            out_sec_q   <= merge_sec_d;
            out_idx_q   <= merge_idx_d;
            out_par_q   <= merge_par_d;
            out_signs_q <= merge_signs_d;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
            beat_q      <= '0;
            run_min_q   <= '1;
            run_sec_q   <= '1;
            run_idx_q   <= '0;
            run_par_q   <= 1'b0;
            run_signs_q <= '0;
        end else begin
            if (accept) begin
                run_min_q   <= merge_min_d;
                run_sec_q   <= merge_sec_d;
                run_idx_q   <= merge_idx_d;
                run_par_q   <= merge_par_d;
                run_signs_q <= merge_signs_d;
                beat_q      <= beat_q + BW'(1);
            end
            if (state_q == HOLD && out_ready) begin
                state_q     <= ACCUM;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_min      = out_min_q;
    assign out_sec_min  = out_sec_q;
    assign out_min_idx  = out_idx_q;
    assign out_sign_par = out_par_q;
    assign out_signs    = out_signs_q;

endmodule

// File: tb/tb_check_node_min_sequencer.sv
// Directed and randomized bench for check_node_min_sequencer; expected row
// results come from a sort-based reference over the whole row.
module tb_check_node_min_sequencer;

    localparam int PREC  = 5;
    localparam int DEG   = 6;
    localparam int GROUP = 3;
    localparam int IDXW  = 3;
    localparam int LW    = PREC + 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [GROUP*LW-1:0]   in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [PREC-1:0]       out_min, out_sec_min;
    logic [IDXW-1:0]       out_min_idx;
    logic                  out_sign_par;
    logic [DEG-1:0]        out_signs;

    int checks = 0;
    int errors = 0;
    int row_m[DEG];
    bit row_s[DEG];
    int e_min, e_sec, e_idx, e_par;
    logic [DEG-1:0] e_signs;
    int last_wait;

    check_node_min_sequencer #(.PREC(PREC), .DEG(DEG), .GROUP(GROUP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_min      (out_min),
        .out_sec_min  (out_sec_min),
        .out_min_idx  (out_min_idx),
        .out_sign_par (out_sign_par),
        .out_signs    (out_signs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sort the row for min/second-min, first occurrence for index.
    task automatic model();
        int q[$];
        q = {};
        for (int j = 0; j < DEG; j++) q.push_back(row_m[j]);
        q.sort();
        e_min = q[0];
        e_sec = q[1];
        e_idx = -1;
        e_par = 0;
        for (int j = 0; j < DEG; j++) begin
            if (e_idx < 0 && row_m[j] == e_min) e_idx = j;
            e_par      = e_par ^ int'(row_s[j]);
            e_signs[j] = row_s[j];
        end
    endtask

    function automatic logic [GROUP*LW-1:0] pack(input int b);
        logic [GROUP*LW-1:0] d;
        d = '0;
        for (int k = 0; k < GROUP; k++)
            d[k*LW +: LW] = {row_s[b*GROUP+k], 5'(row_m[b*GROUP+k])};
        return d;
    endfunction

    task automatic put_beat(input int b);
        bit accepted;
        in_valid  = 1'b1;
        in_data   = pack(b);
        accepted  = 1'b0;
        last_wait = 0;
        #1;
        while (!accepted && last_wait < 20) begin
            if (in_ready) begin
                @(posedge clk); #1;
                accepted = 1'b1;
            end else begin
                @(posedge clk); #1;
                last_wait++;
            end
        end
        chk("beat_accept", 32'(accepted), 32'd1);
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".min"},   32'(out_min), 32'(e_min));
        chk({tag, ".sec"},   32'(out_sec_min), 32'(e_sec));
        chk({tag, ".idx"},   32'(out_min_idx), 32'(e_idx));
        chk({tag, ".par"},   32'(out_sign_par), 32'(e_par));
        chk({tag, ".signs"}, 32'(out_signs), 32'(e_signs));
    endtask

    task automatic send_row(input string tag);
        put_beat(0);
        chk({tag, ".mid_valid"}, 32'(out_valid), 32'd0);
        put_beat(1);
        model();
        check_out(tag);
    endtask

    task automatic idle_after(input string tag);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".retired"}, 32'(out_valid), 32'd0);
    endtask

    task automatic set_row(input int m0, m1, m2, m3, m4, m5, input logic [5:0] s);
        row_m = '{m0, m1, m2, m3, m4, m5};
        for (int j = 0; j < DEG; j++) row_s[j] = s[j];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        out_ready = 1'b1;
        #10;
        chk("rst.valid",  32'(out_valid), 32'd0);
        chk("rst.ready",  32'(in_ready), 32'd1);
        chk("rst.min",    32'(out_min), 32'd0);
        chk("rst.sec",    32'(out_sec_min), 32'd0);
        chk("rst.idx",    32'(out_min_idx), 32'd0);
        chk("rst.par",    32'(out_sign_par), 32'd0);
        chk("rst.signs",  32'(out_signs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_row(7, 3, 9, 3, 12, 1, 6'b110010);
        send_row("rowA");
        chk("rowA.min_lit",   32'(out_min), 32'd1);
        chk("rowA.sec_lit",   32'(out_sec_min), 32'd3);
        chk("rowA.idx_lit",   32'(out_min_idx), 32'd5);
        chk("rowA.signs_lit", 32'(out_signs), 32'b110010);
        idle_after("rowA");

        set_row(4, 4, 4, 4, 4, 4, 6'b000000);
        send_row("all4");
        idle_after("all4");

        set_row(31, 31, 31, 31, 31, 31, 6'b111111);
        send_row("all31");
        chk("all31.idx_lit", 32'(out_min_idx), 32'd0);
        idle_after("all31");

        set_row(2, 9, 9, 5, 8, 6, 6'b010101);
        send_row("beat0min");
        chk("beat0min.sec_lit", 32'(out_sec_min), 32'd5);
        idle_after("beat0min");

        // Backpressure: result held for 5 cycles with the next beat waiting.
        out_ready = 1'b0;
        set_row(20, 18, 22, 25, 19, 30, 6'b001100);
        send_row("bp");
        set_row(6, 6, 17, 2, 9, 2, 6'b100001);
        in_data = pack(0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp.in_ready", 32'(in_ready), 32'd0);
            chk("bp.hold_valid", 32'(out_valid), 32'd1);
            chk("bp.hold_min", 32'(out_min), 32'(e_min));
            chk("bp.hold_idx", 32'(out_min_idx), 32'(e_idx));
            chk("bp.hold_signs", 32'(out_signs), 32'(e_signs));
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp.release_valid", 32'(out_valid), 32'd0);
        put_beat(1);
        model();
        check_out("bp_next");
        idle_after("bp_next");

        // Back-to-back rows: every beat accepted immediately.
        for (int r = 0; r < 8; r++) begin
            for (int j = 0; j < DEG; j++) begin
                row_m[j] = (r % 2 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3);
                row_s[j] = $urandom_range(0, 1);
            end
            put_beat(0);
            chk("b2b.wait0", 32'(last_wait), 32'd0);
            chk("b2b.mid_valid", 32'(out_valid), 32'd0);
            put_beat(1);
            chk("b2b.wait1", 32'(last_wait), 32'd0);
            model();
            check_out("b2b");
        end
        idle_after("b2b");

        // Random gaps between beats and random backpressure lengths.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < DEG; j++) begin
                row_m[j] = $urandom_range(0, 31);
                row_s[j] = $urandom_range(0, 1);
            end
            for (int b = 0; b < 2; b++) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                put_beat(b);
            end
            model();
            check_out("gap");
            in_valid  = 1'b0;
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                chk("gap.hold_min", 32'(out_min), 32'(e_min));
                chk("gap.hold_sec", 32'(out_sec_min), 32'(e_sec));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("gap.retired", 32'(out_valid), 32'd0);
        end

        // Reset after beat 0 discards the partial row.
        set_row(0, 0, 0, 0, 0, 0, 6'b000111);
        put_beat(0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #3;
        chk("midrst.valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("midrst.no_valid", 32'(out_valid), 32'd0);
        end
        set_row(10, 20, 30, 5, 15, 25, 6'b011000);
        send_row("postrst");
        chk("postrst.min_lit", 32'(out_min), 32'd5);
        chk("postrst.idx_lit", 32'(out_min_idx), 32'd3);
        chk("postrst.sec_lit", 32'(out_sec_min), 32'd10);
        idle_after("postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
